// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the sign extender.
//
// Holds the PC, fetches one 32-bit word per instruction from instruction
// memory, presents it with its low 16 bits broken out as the immediate, and
// computes the next PC (sequential, branch or jump) when the instruction
// leaves the stage.
//
// Handshake: imem_req rises the cycle after FETCH_REQ and stays high, with
// imem_addr stable, until a cycle in which imem_ack=1; that cycle's
// imem_rdata is captured and imem_req drops. imem_ack seen while imem_req is
// low (including during and after reset) is ignored.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   imem_addr/imem_req           fetch address and request to memory
//   imem_ack/imem_rdata          memory response
//   stall                        downstream hold while an instruction is issued
//   branch_taken/branch_offset   branch request and sign-extended word offset
//   jump/jump_target             jump request and word-index target field
//   instr/instr_valid/imm16      issued instruction, valid flag, low 16 bits
//   pc_out/pc_plus4              PC of the issued instruction and PC + 4
//   dbg_state                    current FSM state (debug)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] FETCH_REQ  = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] ISSUE      = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;

    // Offset bits above [29:0] are shifted out of a 32-bit address.
    logic unused_ofs_hi;
    assign unused_ofs_hi = ^branch_offset[31:30];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_REQ:  state_d = FETCH_WAIT;
            FETCH_WAIT: if (imem_ack) state_d = ISSUE;
            ISSUE:      if (!stall) state_d = FETCH_REQ;
            default:    state_d = FETCH_REQ;
        endcase
    end

    // Output logic: the request is simply "waiting for memory".
    always_comb begin
        imem_req  = (state_q == FETCH_WAIT);
        dbg_state = state_q;
    end

    // Next PC when leaving ISSUE: jump beats branch beats sequential.
    always_comb begin
        pc_inc = pc_q + 32'd4;
        if (jump) begin
            next_pc = {pc_inc[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_inc + {branch_offset[29:0], 2'b00};
        end else begin
            next_pc = pc_inc;
        end
    end

    // Datapath next-state
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            FETCH_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; the PC never holds a misaligned value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= {pc_d[31:2], 2'b00};
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_inc;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign imm16       = instr_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // memory responder controls
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit spur_ack  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .instr(instr), .instr_valid(instr_valid), .imm16(imm16),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0007;
      32'h0000_0004: mem_word = 32'h2009_8003;
      default:       mem_word = ~a;
    endcase
  endfunction

  // Memory model: acks after ack_delay request cycles without ack.
  always @(negedge clk) begin
    if (spur_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req && wait_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (imem_req) wait_cnt = wait_cnt + 1;
      else          wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (instr_valid) seen = 1;
    end
    check("issue_reached", {31'h0, seen}, 32'h1);
  endtask

  initial begin
    reset_n = 0; stall = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; jump_target = 0; imem_ack = 0; imem_rdata = 0;

    // reset for 2 cycles
    step(); step();
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_imm16", {16'h0, imm16}, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    reset_n = 1;

    // sequential run with zero-wait memory
    step();
    check("seq_req0", {31'h0, imem_req}, 32'h1);
    check("seq_addr0", imem_addr, 32'h0);
    step();
    check("seq_valid0", {31'h0, instr_valid}, 32'h1);
    check("seq_instr0", instr, 32'h2008_0007);
    check("seq_imm0", {16'h0, imm16}, 32'h0000_0007);
    check("seq_pc0", pc_out, 32'h0);
    check("seq_pc4_0", pc_plus4, 32'h4);
    check("seq_req_lo", {31'h0, imem_req}, 32'h0);
    step();
    check("seq_addr1", imem_addr, 32'h4);
    check("seq_valid_clr", {31'h0, instr_valid}, 32'h0);
    wait_issue(10);
    check("seq_instr1", instr, 32'h2009_8003);
    check("seq_imm1", {16'h0, imm16}, 32'h0000_8003);
    check("seq_pc1", pc_out, 32'h4);

    // jump to 0x10 to set up the backward branch
    jump = 1; jump_target = 26'h000_0004;
    step();
    jump = 0;
    check("jmp_addr10", imem_addr, 32'h10);
    wait_issue(10);
    check("br_pc", pc_out, 32'h10);

    // backward branch: 0x14 - 16 = 0x4
    branch_taken = 1; branch_offset = 32'hFFFF_FFFC;
    step();
    check("br_back_addr", imem_addr, 32'h4);
    // branch held through the fetch must be ignored there
    wait_issue(10);
    branch_taken = 0;
    check("br_ignored_fetch", pc_out, 32'h4);

    // branch to 0x1000_0000: 0x8 + 0x0FFF_FFF8
    branch_taken = 1; branch_offset = 32'h03FF_FFFE;
    step();
    branch_taken = 0;
    check("br_fwd_addr", imem_addr, 32'h1000_0000);
    wait_issue(10);
    check("jb_pc", pc_out, 32'h1000_0000);

    // jump beats branch
    jump = 1; jump_target = 26'h000_0040; branch_taken = 1; branch_offset = 32'h4;
    ack_delay = 3;
    step();
    jump = 0; branch_taken = 0;
    check("jb_addr", imem_addr, 32'h1000_0100);

    // slow memory: request held with a constant address for 3 cycles
    stall = 1;  // ignored outside ISSUE
    for (int i = 0; i < 3; i++) begin
      step();
      check("slow_req", {31'h0, imem_req}, 32'h1);
      check("slow_addr", imem_addr, 32'h1000_0100);
      check("slow_valid", {31'h0, instr_valid}, 32'h0);
    end
    wait_issue(10);
    ack_delay = 0;
    check("slow_instr", instr, 32'hEFFF_FEFF);

    // stall holds everything for 4 ISSUE cycles
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_instr", instr, 32'hEFFF_FEFF);
      check("stall_pc", pc_out, 32'h1000_0100);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
    end
    stall = 0;
    step();
    check("unstall_addr", imem_addr, 32'h1000_0104);
    wait_issue(10);
    check("unstall_instr", instr, 32'hEFFF_FEFB);

    // spurious ack in ISSUE must not change instr
    stall = 1; spur_ack = 1;
    step(); step();
    check("spur_instr", instr, 32'hEFFF_FEFB);
    spur_ack = 0;
    step();
    check("spur_instr2", instr, 32'hEFFF_FEFB);

    // branch to 0xFFFF_FFFC: 0x1000_0108 + 0xEFFF_FEF4
    stall = 0; branch_taken = 1; branch_offset = 32'h3BFF_FFBD;
    step();
    branch_taken = 0;
    check("wrap_setup_addr", imem_addr, 32'hFFFF_FFFC);
    wait_issue(10);
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    check("wrap_instr", instr, 32'h0000_0003);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    wait_issue(10);
    check("wrap_instr0", instr, 32'h2008_0007);

    // reset mid-fetch at 0x40 with an ack in the same cycle
    jump = 1; jump_target = 26'h000_0010;
    step();
    jump = 0;
    step();
    check("mid_req", {31'h0, imem_req}, 32'h1);
    check("mid_addr", imem_addr, 32'h40);
    reset_n = 0;
    step();
    reset_n = 1;
    check("mid_instr", instr, 32'h0);
    check("mid_valid", {31'h0, instr_valid}, 32'h0);
    check("mid_req_lo", {31'h0, imem_req}, 32'h0);
    check("mid_pc", pc_out, 32'h0);
    step();
    check("mid_refetch_req", {31'h0, imem_req}, 32'h1);
    check("mid_refetch_addr", imem_addr, 32'h0);
    wait_issue(10);
    check("mid_refetch_instr", instr, 32'h2008_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage upstream of the sign extender.
- Holds the PC and fetches a 32-bit instruction from instruction memory over a req/ack handshake.
- Presents the instruction, with its low 16 bits broken out as the immediate that feeds the sign extender.
- Computes the next PC: sequential, branch (using the 32-bit sign-extended offset returned from the sign extender) or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; one clock; reset is synchronous and active-low
- imem_addr  output  32  instruction memory address (= current PC)
- imem_req  output  1  fetch request; held high until ack
- imem_ack  input  1  memory has returned imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- stall  input  1  downstream hold; freezes instruction and PC
- branch_taken  input  1  take branch at end of current instruction
- branch_offset  input  32  sign-extended immediate (word offset) from the sign extender
- jump  input  1  take jump at end of current instruction
- jump_target  input  26  instruction word-index field
- instr  output  32  latched instruction
- instr_valid  output  1  instr holds a valid, issued instruction
- imm16  output  16  instr[15:0], to sign extender input
- pc_out  output  32  PC of the instruction in instr
- pc_plus4  output  32  pc_out + 4

Behaviour:
- Reset, when reset_n=0 at a rising edge:
  - state=FETCH, PC={RESET_PC[31:2],2'b00}.
  - instr=0, instr_valid=0, imem_req=0.
  - Reset takes priority over all other inputs.
  - A fetch in flight is abandoned; an ack arriving during or after the reset cycle is ignored until a new request is issued.
- States: FETCH_REQ, FETCH_WAIT, ISSUE.
  - After reset the state is FETCH_REQ.
- FETCH_REQ:
  - Next cycle: imem_req=1, imem_addr=PC, go to FETCH_WAIT.
- FETCH_WAIT:
  - imem_req stays 1 and imem_addr stays stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to ISSUE.
  - Ack latency 0..N cycles; with a zero-wait memory, ack may arrive in the first FETCH_WAIT cycle. Minimum fetch-to-issue is 2 cycles.
- ISSUE:
  - instr_valid=1, with instr, imm16 and pc_out stable.
  - If stall=1: hold everything, with no PC update and branch/jump ignored that cycle.
  - If stall=0: update PC, clear instr_valid, go to FETCH_REQ.
- Next-PC priority when leaving ISSUE: jump > branch_taken > sequential.
  - Jump: PC={pc_plus4[31:28], jump_target, 2'b00}.
  - Branch: PC=pc_plus4 + {branch_offset[29:0],2'b00}, modulo 2^32. A negative offset wraps correctly.
  - Sequential: PC=pc_plus4, which wraps 32'hFFFF_FFFC -> 0.
- branch_taken, jump and stall are sampled only in ISSUE; they are ignored in the fetch states.
- imm16 is combinational from instr (instr[15:0]). It is 0 after reset.
- pc_plus4 is combinational from pc_out.
  - pc_out is the PC of the fetched instruction and updates when the PC register is written.
- imem_ack outside FETCH_WAIT is ignored; an unexpected ack must not change instr.
- PC bits [1:0] are always 0.

Test Plan:
- Reset then sequential run: reset_n=0 for 2 cycles, RESET_PC=0, zero-wait memory returning 32'h2008_0007 at addr 0 and 32'h2009_8003 at addr 4 -> imem_addr 0 then 4; instr=32'h2008_0007 with imm16=16'h0007, pc_out=0; next instr=32'h2009_8003 with imm16=16'h8003, pc_out=4.
- Backward branch: at pc_out=32'h0000_0010, branch_taken=1, branch_offset=32'hFFFF_FFFC -> next imem_addr=32'h0000_0004.
- Jump over branch: at pc_out=32'h1000_0000, jump=1 with jump_target=26'h000_0040 and branch_taken=1 -> next imem_addr=32'h1000_0100.
- Slow memory and stall:
  - Ack delayed 3 cycles -> imem_req high with imem_addr constant for all 3 cycles.
  - Then stall=1 for 4 ISSUE cycles -> instr, pc_out and instr_valid unchanged, with no new request.
  - On stall=0 -> fetch at pc_plus4.
- Reset mid-fetch: reset_n=0 while in FETCH_WAIT at addr 32'h40, and ack arrives in the same cycle -> instr=0, instr_valid=0, and next request at RESET_PC.
- Wrap-around and spurious ack:
  - Sequential from pc_out=32'hFFFF_FFFC -> next imem_addr=0.
  - imem_ack=1 asserted in ISSUE -> instr unchanged.
